pkt_rr_arbiter: RTL and testbench

PKT_RR_ARBITER -- requirements
Module: pkt_rr_arbiter

---
 rtl/pkt_arb_pkg.sv | 13 +
 rtl/pkt_rr_arbiter_rr_pick.sv | 34 +++
 rtl/pkt_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_pkt_rr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the packet round-robin arbiter.
package pkt_arb_pkg;

  // Arbiter FSM: ARB picks the next stream, PASS forwards one packet.
  typedef enum logic {
    ARB  = 1'b0,
    PASS = 1'b1
  } arb_state_e;

  // Width of each per-stream packet counter.
  localparam int unsigned C_CNT_WIDTH = 32;

endpackage

// File: rtl/pkt_rr_arbiter_rr_pick.sv
// Rotate-priority search: first requesting stream after last_grant, wrapping.
module rr_pick
  import pkt_arb_pkg::*;
#(
  parameter int unsigned C_NUM_QUEUES = 4
) (
  input  logic [C_NUM_QUEUES-1:0]         req,
  input  logic [$clog2(C_NUM_QUEUES)-1:0] last_grant,
  output logic                            found,
  output logic [$clog2(C_NUM_QUEUES)-1:0] idx
);

  localparam int unsigned C_IDX_W = $clog2(C_NUM_QUEUES);

  int unsigned        w_pos;
  logic [C_IDX_W-1:0] w_cand;

  // Walk offsets 1..N from last_grant; the first hit wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_pos  = 0;
    w_cand = '0;
    for (int unsigned k = 1; k <= C_NUM_QUEUES; k++) begin
      w_pos  = (32'(last_grant) + k) % C_NUM_QUEUES;
      w_cand = w_pos[C_IDX_W-1:0];
      if (!found && req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-level round-robin arbiter over C_NUM_QUEUES AXI-Stream inputs.
// A grant is held for a whole packet (until an accepted tlast beat), with one
// arbitration cycle between packets. Outputs are registered.
// Optional macro PKT_RR_ARBITER_STATS_EN adds per-stream packet counters on
// output pkt_cnt.
module pkt_rr_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int unsigned C_NUM_QUEUES = 4,
  parameter int unsigned C_DATA_WIDTH = 8,
  parameter int unsigned C_MTY_WIDTH  = 8
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic [C_NUM_QUEUES-1:0]               s_axis_tvalid,
  input  logic [C_NUM_QUEUES*C_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [C_NUM_QUEUES-1:0]               s_axis_tlast,
  input  logic [C_NUM_QUEUES*C_MTY_WIDTH-1:0]   s_axis_tuser_mty,
  output logic [C_NUM_QUEUES-1:0]               s_axis_tready,
  output logic                                  m_axis_tvalid,
  output logic [C_DATA_WIDTH-1:0]               m_axis_tdata,
  output logic                                  m_axis_tlast,
  output logic [C_MTY_WIDTH-1:0]                m_axis_tuser_mty,
  input  logic                                  m_axis_tready,
  output logic [$clog2(C_NUM_QUEUES)-1:0]       grant_idx,
  output logic                                  busy
`ifdef PKT_RR_ARBITER_STATS_EN
  ,
  output logic [C_NUM_QUEUES*C_CNT_WIDTH-1:0]   pkt_cnt
`endif
);

  localparam int unsigned C_IDX_W = $clog2(C_NUM_QUEUES);

  arb_state_e          r_state;
  logic [C_IDX_W-1:0]  r_last_grant;
  logic [C_IDX_W-1:0]  r_grant;

  logic                    r_m_tvalid;
  logic [C_DATA_WIDTH-1:0] r_m_tdata;
  logic                    r_m_tlast;
  logic [C_MTY_WIDTH-1:0]  r_m_tmty;

  logic                w_found;
  logic [C_IDX_W-1:0]  w_pick;
  logic                w_slot_ready;
  logic                w_accept;
  logic                w_accept_last;
  int unsigned         w_gsel;

  rr_pick #(
    .C_NUM_QUEUES(C_NUM_QUEUES)
  ) u_pick (
    .req        (s_axis_tvalid),
    .last_grant (r_last_grant),
    .found      (w_found),
    .idx        (w_pick)
  );

  // Handshake decode for the granted stream; output slot frees when drained.
  always_comb begin
    w_gsel        = 32'(r_grant);
    w_slot_ready  = m_axis_tready | ~r_m_tvalid;
    s_axis_tready = '0;
    if (r_state == PASS) begin
      s_axis_tready[r_grant] = w_slot_ready;
    end
    w_accept      = (r_state == PASS) && s_axis_tvalid[r_grant] && w_slot_ready;
    w_accept_last = w_accept && s_axis_tlast[r_grant];
  end

  // Arbitration FSM: grant in ARB, hold grant until the packet's last beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= ARB;
      r_last_grant <= C_IDX_W'(C_NUM_QUEUES - 1);
      r_grant      <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= PASS;
          end
        end
        PASS: begin
          if (w_accept_last) begin
            r_last_grant <= r_grant;
            r_state      <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  // Output register: load on accept, otherwise drain when downstream is ready.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tmty   <= '0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= s_axis_tdata[w_gsel*C_DATA_WIDTH +: C_DATA_WIDTH];
      r_m_tlast  <= s_axis_tlast[r_grant];
      r_m_tmty   <= s_axis_tuser_mty[w_gsel*C_MTY_WIDTH +: C_MTY_WIDTH];
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_axis_tvalid    = r_m_tvalid;
  assign m_axis_tdata     = r_m_tdata;
  assign m_axis_tlast     = r_m_tlast;
  assign m_axis_tuser_mty = r_m_tmty;
  assign grant_idx        = r_grant;
  assign busy             = (r_state == PASS);

`ifdef PKT_RR_ARBITER_STATS_EN
  logic [C_CNT_WIDTH-1:0] r_pkt_cnt [C_NUM_QUEUES];

  // Count accepted tlast beats per stream; wraps naturally at 2^32.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int unsigned i = 0; i < C_NUM_QUEUES; i++) begin
        r_pkt_cnt[i] <= '0;
      end
    end else if (w_accept_last) begin
      r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + C_CNT_WIDTH'(1);
    end
  end

  // Flatten counters onto the output bus, stream i at slice i.
  always_comb begin
    pkt_cnt = '0;
    for (int unsigned i = 0; i < C_NUM_QUEUES; i++) begin
      pkt_cnt[i*C_CNT_WIDTH +: C_CNT_WIDTH] = r_pkt_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Self-checking bench for pkt_rr_arbiter (4 streams, 8-bit data/mty).
// Sources are per-stream beat queues that present their next beat whenever
// non-empty; a packet-level round-robin model predicts the output order.
module tb_pkt_rr_arbiter;

  localparam int NQ = 4;

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic [7:0]  mty;
    int unsigned strm;
  } beat_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic [3:0]    s_tvalid;
  logic [31:0]   s_tdata;
  logic [3:0]    s_tlast;
  logic [31:0]   s_tmty;
  logic [3:0]    s_tready;
  logic          m_tvalid;
  logic [7:0]    m_tdata;
  logic          m_tlast;
  logic [7:0]    m_tmty;
  logic          m_tready;
  logic [1:0]    grant_idx;
  logic          busy;
`ifdef PKT_RR_ARBITER_STATS_EN
  logic [127:0]  pkt_cnt;
`endif

  pkt_rr_arbiter #(
    .C_NUM_QUEUES(4),
    .C_DATA_WIDTH(8),
    .C_MTY_WIDTH (8)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tdata    (s_tdata),
    .s_axis_tlast    (s_tlast),
    .s_axis_tuser_mty(s_tmty),
    .s_axis_tready   (s_tready),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tdata    (m_tdata),
    .m_axis_tlast    (m_tlast),
    .m_axis_tuser_mty(m_tmty),
    .m_axis_tready   (m_tready),
    .grant_idx       (grant_idx),
    .busy            (busy)
`ifdef PKT_RR_ARBITER_STATS_EN
    ,
    .pkt_cnt         (pkt_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  int          checks = 0;
  int          errors = 0;
  beat_t       src_q  [NQ][$];
  beat_t       pend_q [NQ][$];
  beat_t       exp_q  [$];
  int          beat_cyc [$];
  int          exp_cnt [NQ];
  int          model_last;
  int          cyc = 0;
  bit          chk_grant = 0;
  bit          chk_hold  = 0;
  logic [7:0]  hold_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present the head beat of each source queue.
  task automatic drive();
    for (int i = 0; i < NQ; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i]       = 1'b1;
        s_tdata[i*8 +: 8] = src_q[i][0].data;
        s_tlast[i]        = src_q[i][0].last;
        s_tmty[i*8 +: 8]  = src_q[i][0].mty;
      end else begin
        s_tvalid[i]       = 1'b0;
        s_tdata[i*8 +: 8] = '0;
        s_tlast[i]        = 1'b0;
        s_tmty[i*8 +: 8]  = '0;
      end
    end
  endtask

  task automatic add_pkt(input int strm, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = 8'($urandom);
      b.mty  = 8'($urandom);
      b.last = (k == len - 1);
      b.strm = strm;
      src_q[strm].push_back(b);
      pend_q[strm].push_back(b);
    end
  endtask

  // Packet-level round robin over pending packets; all sources stay valid.
  task automatic plan();
    bit any;
    int s;
    beat_t b;
    any = 1;
    while (any) begin
      any = 0;
      for (int off = 1; off <= NQ && !any; off++) begin
        s = (model_last + off) % NQ;
        if (pend_q[s].size() > 0) begin
          any = 1;
          do begin
            b = pend_q[s].pop_front();
            exp_q.push_back(b);
          end while (!b.last);
          model_last = s;
        end
      end
    end
  endtask

  task automatic step();
    logic [3:0] s_acc;
    logic       out_acc;
    logic [7:0] od;
    logic       ol;
    logic [7:0] om;
    logic [1:0] og;
    beat_t      e;
    @(negedge aclk);
    s_acc   = s_tvalid & s_tready;
    out_acc = m_tvalid & m_tready;
    od = m_tdata; ol = m_tlast; om = m_tmty; og = grant_idx;
    if (chk_hold) begin
      check("stall_valid", 32'(m_tvalid), 32'(1));
      check("stall_data", 32'(m_tdata), 32'(hold_exp));
      check("stall_sready", 32'(s_tready), 32'(0));
    end
    @(posedge aclk);
    #1;
    cyc++;
    if (out_acc) begin
      check("beat_expected", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("beat", {15'd0, od, ol, om}, {15'd0, e.data, e.last, e.mty});
        if (chk_grant) check("beat_grant", 32'(og), e.strm);
        beat_cyc.push_back(cyc);
        if (e.last) exp_cnt[e.strm]++;
      end
    end
    for (int i = 0; i < NQ; i++) begin
      if (s_acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive();
  endtask

  task automatic run_all(input int maxc, input bit rnd);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < maxc) begin
      if (rnd) m_tready = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic do_reset();
    areset = 1'b1;
    for (int i = 0; i < NQ; i++) begin
      src_q[i].delete();
      pend_q[i].delete();
      exp_cnt[i] = 0;
    end
    exp_q.delete();
    beat_cyc.delete();
    drive();
    @(posedge aclk);
    #1;
    areset     = 1'b0;
    model_last = NQ - 1;
  endtask

  initial begin
    int n;
    m_tready = 1'b1;
    do_reset();
    do_reset();

    // Reset values
    check("rst_mvalid", 32'(m_tvalid), 32'(0));
    check("rst_mdata", 32'(m_tdata), 32'(0));
    check("rst_mlast", 32'(m_tlast), 32'(0));
    check("rst_mmty", 32'(m_tmty), 32'(0));
    check("rst_sready", 32'(s_tready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_grant", 32'(grant_idx), 32'(0));

    // Single-beat packets on all streams: 0,1,2,3,0 at one packet per 2 cycles
    chk_grant = 1;
    add_pkt(0, 1); add_pkt(1, 1); add_pkt(2, 1); add_pkt(3, 1); add_pkt(0, 1);
    plan();
    drive();
    run_all(100, 0);
    check("rr_beats", 32'(beat_cyc.size()), 32'(5));
    for (int k = 0; k < 4; k++) begin
      if (k + 1 < beat_cyc.size()) check("pkt_period", 32'(beat_cyc[k+1] - beat_cyc[k]), 32'(2));
    end

    // Park last_grant at 1, then stream 2 (5 beats) against a waiting stream 0
    add_pkt(1, 1);
    plan();
    drive();
    run_all(50, 0);
    add_pkt(2, 5);
    add_pkt(0, 2);
    plan();
    drive();
    run_all(100, 0);

    // Downstream stall for 3 cycles mid-packet
    add_pkt(2, 4);
    plan();
    drive();
    n = 0;
    while (exp_q.size() > 2 && n < 20) begin
      step();
      n++;
    end
    check("stall_setup", 32'(exp_q.size()), 32'(2));
    hold_exp = exp_q[0].data;
    m_tready = 1'b0;
    chk_hold = 1;
    repeat (3) step();
    chk_hold = 0;
    m_tready = 1'b1;
    run_all(50, 0);

    // Lone stream 3 with last_grant=3 is re-granted after one ARB cycle
    do_reset();
    add_pkt(3, 2);
    add_pkt(3, 1);
    plan();
    drive();
    run_all(50, 0);
    check("regrant_beats", 32'(beat_cyc.size()), 32'(3));
    if (beat_cyc.size() == 3) check("regrant_gap", 32'(beat_cyc[2] - beat_cyc[1]), 32'(2));

    // Reset during beat 2 of a 4-beat packet on stream 1
    add_pkt(1, 4);
    plan();
    drive();
    n = 0;
    while (src_q[1].size() > 3 && n < 20) begin
      step();
      n++;
    end
    check("midrst_setup", 32'(src_q[1].size()), 32'(3));
    do_reset();
    check("midrst_mvalid", 32'(m_tvalid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    add_pkt(2, 1);
    add_pkt(0, 1);
    plan();
    drive();
    step();
    check("midrst_grant", 32'(grant_idx), 32'(0));
    check("midrst_busy_pass", 32'(busy), 32'(1));
    run_all(50, 0);

    // Randomized packets with random downstream backpressure
    chk_grant = 0;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(3, 10);
      for (int p = 0; p < n; p++) add_pkt($urandom_range(0, 3), $urandom_range(1, 6));
      plan();
      drive();
      run_all(3000, 1);
      m_tready = 1'b1;
    end

`ifdef PKT_RR_ARBITER_STATS_EN
    // Seven packets on stream 1 after reset
    do_reset();
    for (int p = 0; p < 7; p++) add_pkt(1, $urandom_range(1, 3));
    plan();
    drive();
    run_all(500, 0);
    for (int i = 0; i < NQ; i++) begin
      check("pkt_cnt", pkt_cnt[i*32 +: 32], (i == 1) ? 32'(7) : 32'(0));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
